// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with PC redirect; FETCH_STATS_EN adds fetch/redirect counters
module fetch_stage #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            decode_ready_i,
    input  logic            PCSrc_i,
    input  logic [XLEN-1:0] PCTarget_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
`ifdef FETCH_STATS_EN
    output logic [31:0]     fetch_count_o,
    output logic [31:0]     redirect_count_o,
`endif
    output logic            instr_valid_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state_q, state_d;
    logic [XLEN-1:0] pc_q, req_addr_q, pc_out_q;
    logic [31:0] instr_q;
    logic valid_q, discard_q;
    logic consume, fetch_req, grant, resp, redirect;
    assign consume = valid_q & decode_ready_i;
    assign fetch_req = (state_q == REQ) & (~valid_q | consume);
    assign grant = fetch_req & imem_ready_i;
    assign resp = (state_q == WAIT) & imem_rvalid_i;
    assign redirect = consume & PCSrc_i;
    assign imem_req_o = fetch_req;
    assign imem_addr_o = pc_q;
    assign instr_o = instr_q;
    assign pc_o = pc_out_q;
    assign pc_plus4_o = pc_out_q + XLEN'(4);
    assign instr_valid_o = valid_q;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     state_d = grant ? WAIT : REQ;
            WAIT:    state_d = imem_rvalid_i ? REQ : WAIT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state_q <= IDLE;
        else state_q <= state_d;
    // a grant in the redirect cycle fetched the stale sequential address, so its word is dropped
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            pc_out_q   <= RESET_PC;
            instr_q    <= 32'h0000_0013;
            valid_q    <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            if (redirect) pc_q <= {PCTarget_i[XLEN-1:2], 2'b00};
            else if (grant) pc_q <= pc_q + XLEN'(4);
            if (grant) begin
                req_addr_q <= pc_q;
                discard_q  <= redirect;
            end else if (resp) discard_q <= 1'b0;
            if (resp & ~discard_q) begin
                instr_q  <= imem_rdata_i;
                pc_out_q <= req_addr_q;
                valid_q  <= 1'b1;
            end else if (consume) valid_q <= 1'b0;
        end
`ifdef FETCH_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            fetch_count_o    <= '0;
            redirect_count_o <= '0;
        end else begin
            if (resp & ~discard_q) fetch_count_o <= fetch_count_o + 32'd1;
            if (redirect) redirect_count_o <= redirect_count_o + 32'd1;
        end
`endif
endmodule
